// File: rtl/ahb_slave_if_gen_if.sv
// rtl/ahb_slave_if_gen_if.sv - AHB-side bus bundle between the AHB master and the slave interface block
interface ahb_slave_if_gen_if #(
   parameter int DW   = 32,
   parameter int AW   = 32,
   parameter int NSLV = 3
);
   logic            Hwrite;
   logic            Hreadyin;
   logic [1:0]      Htrans;
   logic [AW-1:0]   Haddr;
   logic [DW-1:0]   Hwdata;
   logic [DW-1:0]   Prdata;
   logic            Pready_br;
   logic [AW-1:0]   Haddr1;
   logic [AW-1:0]   Haddr2;
   logic [DW-1:0]   Hwdata1;
   logic [DW-1:0]   Hwdata2;
   logic            Hwritereg;
   logic            Hwritereg1;
   logic            valid;
   logic [NSLV-1:0] tempselx;
   logic            Hreadyout;
   logic [1:0]      Hresp;
   logic [DW-1:0]   Hrdata;
   logic [7:0]      err_cnt;

   modport master (
      output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready_br,
      input  Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
      input  valid, tempselx, Hreadyout, Hresp, Hrdata, err_cnt
   );

   modport slave (
      input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, Pready_br,
      output Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, Hwritereg1,
      output valid, tempselx, Hreadyout, Hresp, Hrdata, err_cnt
   );
endinterface

// File: rtl/ahb_slave_if_gen.sv
// rtl/ahb_slave_if_gen.sv - AHB slave front end: slot decode, address/data pipeline, ERROR response FSM
module ahb_slave_if_gen #(
   parameter int          DW           = 32,
   parameter int          AW           = 32,
   parameter int          NSLV         = 3,
   parameter logic [31:0] BASE         = 32'h8000_0000,
   parameter int          SLOT_SZ_LOG2 = 26
) (
   input logic              Hclk,
   input logic              Hresetn,
   ahb_slave_if_gen_if.slave bus
);
   // Decode arithmetic is done a few bits wider than the bus so BASE + span cannot wrap.
   localparam int            XW     = AW + 5;
   localparam logic [XW-1:0] BASE_X = XW'(BASE);
   localparam logic [XW-1:0] SPAN_X = XW'(NSLV) << SLOT_SZ_LOG2;

   typedef enum logic [1:0] {S_OKAY = 2'd0, S_ERR1 = 2'd1, S_ERR2 = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [7:0]      err_cnt_q, err_cnt_d;
   logic [AW-1:0]   haddr1_q, haddr2_q;
   logic [DW-1:0]   hwdata1_q, hwdata2_q;
   logic            hwrite1_q, hwrite2_q;
   logic [NSLV-1:0] sel;
   logic [XW-1:0]   addr_x, off_x, slot_x;
   logic            in_rng, unmapped;
   logic            hreadyout, hresp_err;

   // Combinational slot decode; at most one bit can match since slot_x is a single index.
   always_comb begin
      sel    = '0;
      addr_x = XW'(bus.Haddr);
      off_x  = addr_x - BASE_X;
      slot_x = off_x >> SLOT_SZ_LOG2;
      in_rng = (addr_x >= BASE_X) && (off_x < SPAN_X);
      for (int k = 0; k < NSLV; k++) begin
         if (Hresetn && in_rng && (slot_x == XW'(k)))
            sel[k] = 1'b1;
      end
   end

   // An active (NONSEQ/SEQ) transfer sampled on the bus with no slot behind it.
   assign unmapped = bus.Hreadyin && bus.Htrans[1] && (sel == '0);

   // Pipeline stages advance only when the bus is ready, otherwise hold.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         haddr1_q  <= '0;
         haddr2_q  <= '0;
         hwdata1_q <= '0;
         hwdata2_q <= '0;
         hwrite1_q <= 1'b0;
         hwrite2_q <= 1'b0;
      end else if (bus.Hreadyin) begin
         haddr1_q  <= bus.Haddr;
         haddr2_q  <= haddr1_q;
         hwdata1_q <= bus.Hwdata;
         hwdata2_q <= hwdata1_q;
         hwrite1_q <= bus.Hwrite;
         hwrite2_q <= hwrite1_q;
      end
   end

   // Response FSM state and error counter registers.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q   <= S_OKAY;
         err_cnt_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Two-cycle ERROR response: first cycle holds the master off, second completes it.
   always_comb begin
      state_d   = state_q;
      hreadyout = bus.Pready_br;
      hresp_err = 1'b0;
      case (state_q)
         S_OKAY: begin
            if (unmapped)
               state_d = S_ERR1;
         end
         S_ERR1: begin
            hresp_err = 1'b1;
            hreadyout = 1'b0;
            state_d   = S_ERR2;
         end
         S_ERR2: begin
            hresp_err = 1'b1;
            hreadyout = 1'b1;
            state_d   = unmapped ? S_ERR1 : S_OKAY;
         end
         default: begin
            state_d = S_OKAY;
         end
      endcase
      // ERR1 always exits to ERR2, so any next-state of ERR1 is a fresh entry.
      err_cnt_d = err_cnt_q;
      if ((state_d == S_ERR1) && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'h01;
   end

   assign bus.tempselx   = sel;
   assign bus.valid      = Hresetn && bus.Hreadyin && bus.Htrans[1] && (sel != '0);
   assign bus.Haddr1     = haddr1_q;
   assign bus.Haddr2     = haddr2_q;
   assign bus.Hwdata1    = hwdata1_q;
   assign bus.Hwdata2    = hwdata2_q;
   assign bus.Hwritereg  = hwrite1_q;
   assign bus.Hwritereg1 = hwrite2_q;
   assign bus.Hreadyout  = hreadyout;
   assign bus.Hresp      = {1'b0, hresp_err};
   assign bus.Hrdata     = bus.Prdata;
   assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// tb/tb_ahb_slave_if_gen.sv - directed table and sequence checks for ahb_slave_if_gen
module tb_ahb_slave_if_gen;
   logic Hclk = 1'b0;
   logic Hresetn = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   always #5 Hclk = ~Hclk;

   ahb_slave_if_gen_if #(.DW(32), .AW(32), .NSLV(3)) bus ();
   ahb_slave_if_gen_if #(.DW(32), .AW(32), .NSLV(8)) bus8 ();

   ahb_slave_if_gen dut (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .bus     (bus.slave)
   );

   ahb_slave_if_gen #(.NSLV(8), .SLOT_SZ_LOG2(20)) dut8 (
      .Hclk    (Hclk),
      .Hresetn (Hresetn),
      .bus     (bus8.slave)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        rdy;
      logic [2:0]  sel;
      logic        vld;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   initial begin
      tbl[0] = '{32'h8000_0000, 2'b10, 1'b1, 3'b001, 1'b1};
      tbl[1] = '{32'h8400_0010, 2'b10, 1'b1, 3'b010, 1'b1};
      tbl[2] = '{32'h8BFF_FFFC, 2'b10, 1'b1, 3'b100, 1'b1};
      tbl[3] = '{32'h8C00_0000, 2'b10, 1'b1, 3'b000, 1'b0};
      tbl[4] = '{32'h7FFF_FFFC, 2'b10, 1'b1, 3'b000, 1'b0};
      tbl[5] = '{32'h8400_0010, 2'b11, 1'b1, 3'b010, 1'b1};
      tbl[6] = '{32'h8400_0010, 2'b01, 1'b1, 3'b010, 1'b0};
      tbl[7] = '{32'h8000_0004, 2'b00, 1'b1, 3'b001, 1'b0};
      tbl[8] = '{32'h8000_0004, 2'b10, 1'b0, 3'b001, 1'b0};
      tbl[9] = '{32'hFFFF_FFFC, 2'b10, 1'b1, 3'b000, 1'b0};

      bus.Hwrite = 1'b0;  bus.Hreadyin = 1'b1;  bus.Htrans = 2'b00;
      bus.Haddr = 32'h8400_0010;  bus.Hwdata = '0;
      bus.Prdata = 32'hCAFE_F00D;  bus.Pready_br = 1'b1;
      bus8.Hwrite = 1'b0;  bus8.Hreadyin = 1'b1;  bus8.Htrans = 2'b00;
      bus8.Haddr = '0;  bus8.Hwdata = '0;  bus8.Prdata = '0;  bus8.Pready_br = 1'b1;

      // Reset state
      #2;
      chk("rst_hresp", 64'(bus.Hresp), 64'h0);
      chk("rst_valid", 64'(bus.valid), 64'h0);
      chk("rst_sel", 64'(bus.tempselx), 64'h0);
      chk("rst_errcnt", 64'(bus.err_cnt), 64'h0);
      chk("rst_haddr1", 64'(bus.Haddr1), 64'h0);
      chk("rst_hready_p1", 64'(bus.Hreadyout), 64'h1);
      bus.Pready_br = 1'b0;
      #1;
      chk("rst_hready_p0", 64'(bus.Hreadyout), 64'h0);
      chk("hrdata", 64'(bus.Hrdata), 64'hCAFE_F00D);
      bus.Pready_br = 1'b1;
      tick();
      Hresetn = 1'b1;
      tick();

      // Decode table
      for (int i = 0; i < 10; i++) begin
         bus.Haddr = tbl[i].addr;
         bus.Htrans = tbl[i].trans;
         bus.Hreadyin = tbl[i].rdy;
         #1;
         chk($sformatf("tbl%0d_sel", i), 64'(bus.tempselx), 64'(tbl[i].sel));
         chk($sformatf("tbl%0d_valid", i), 64'(bus.valid), 64'(tbl[i].vld));
         tick();
      end
      bus.Htrans = 2'b00;
      bus.Hreadyin = 1'b1;
      #1;
      Hresetn = 1'b0;
      #1;
      Hresetn = 1'b1;
      tick();

      // Address/write pipeline
      bus.Haddr = 32'h8400_0010;  bus.Htrans = 2'b10;  bus.Hwrite = 1'b1;
      bus.Hwdata = 32'h1111_1111;
      tick();
      chk("pipe_haddr1", 64'(bus.Haddr1), 64'h8400_0010);
      chk("pipe_hwrite1", 64'(bus.Hwritereg), 64'h1);
      bus.Haddr = 32'h8000_0000;  bus.Htrans = 2'b00;  bus.Hwrite = 1'b0;
      bus.Hwdata = 32'h2222_2222;
      tick();
      chk("pipe_haddr2", 64'(bus.Haddr2), 64'h8400_0010);
      chk("pipe_haddr1b", 64'(bus.Haddr1), 64'h8000_0000);
      chk("pipe_hwrite2", 64'(bus.Hwritereg1), 64'h1);
      chk("pipe_hwdata1", 64'(bus.Hwdata1), 64'h2222_2222);
      chk("pipe_hwdata2", 64'(bus.Hwdata2), 64'h1111_1111);

      // Hold while Hreadyin low
      bus.Hreadyin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.Hwdata = 32'hA000_0000 + 32'(i);
         bus.Haddr = 32'h8800_0000 + 32'(i);
         tick();
      end
      chk("hold_hwdata1", 64'(bus.Hwdata1), 64'h2222_2222);
      chk("hold_hwdata2", 64'(bus.Hwdata2), 64'h1111_1111);
      chk("hold_haddr1", 64'(bus.Haddr1), 64'h8000_0000);
      bus.Hreadyin = 1'b1;

      // Single unmapped NONSEQ
      bus.Haddr = 32'h8C00_0000;  bus.Htrans = 2'b10;
      #1;
      chk("err_valid", 64'(bus.valid), 64'h0);
      chk("err_sel", 64'(bus.tempselx), 64'h0);
      chk("err_okay_before", 64'(bus.Hresp), 64'h0);
      tick();
      bus.Htrans = 2'b00;
      bus.Pready_br = 1'b1;
      #1;
      chk("err1_hresp", 64'(bus.Hresp), 64'h1);
      chk("err1_hready", 64'(bus.Hreadyout), 64'h0);
      chk("err1_cnt", 64'(bus.err_cnt), 64'h1);
      tick();
      bus.Pready_br = 1'b0;
      #1;
      chk("err2_hresp", 64'(bus.Hresp), 64'h1);
      chk("err2_hready", 64'(bus.Hreadyout), 64'h1);
      tick();
      chk("err_done_hresp", 64'(bus.Hresp), 64'h0);
      chk("err_done_cnt", 64'(bus.err_cnt), 64'h1);

      // Pready_br passthrough in OKAY, BUSY at unmapped address
      chk("okay_pready0", 64'(bus.Hreadyout), 64'h0);
      bus.Pready_br = 1'b1;
      #1;
      chk("okay_pready1", 64'(bus.Hreadyout), 64'h1);
      bus.Htrans = 2'b01;
      tick();
      tick();
      chk("busy_hresp", 64'(bus.Hresp), 64'h0);
      chk("busy_cnt", 64'(bus.err_cnt), 64'h1);

      // Back-to-back unmapped: ERR2 re-enters ERR1, then saturation
      bus.Htrans = 2'b10;
      tick();
      tick();
      tick();
      chk("b2b_hready", 64'(bus.Hreadyout), 64'h0);
      chk("b2b_hresp", 64'(bus.Hresp), 64'h1);
      chk("b2b_cnt", 64'(bus.err_cnt), 64'h3);
      for (int i = 0; i < 600; i++) tick();
      chk("sat_cnt", 64'(bus.err_cnt), 64'hFF);
      begin
         int budget;
         budget = 4;
         while (bus.Hreadyout !== 1'b0 && budget > 0) begin
            tick();
            budget--;
         end
         chk("find_err1", 64'(bus.Hreadyout), 64'h0);
      end
      #2;
      Hresetn = 1'b0;
      #1;
      chk("rst_err1_hresp", 64'(bus.Hresp), 64'h0);
      chk("rst_err1_cnt", 64'(bus.err_cnt), 64'h0);
      chk("rst_err1_hready", 64'(bus.Hreadyout), 64'h1);
      bus.Htrans = 2'b00;
      tick();
      Hresetn = 1'b1;
      tick();

      // Eight 1MB slots
      bus8.Haddr = 32'h8070_0000;  bus8.Htrans = 2'b10;
      #1;
      chk("n8_sel", 64'(bus8.tempselx), 64'h80);
      chk("n8_valid", 64'(bus8.valid), 64'h1);
      tick();
      bus8.Haddr = 32'h8080_0000;
      #1;
      chk("n8_oob_sel", 64'(bus8.tempselx), 64'h0);
      tick();
      bus8.Htrans = 2'b00;
      #1;
      chk("n8_oob_hresp", 64'(bus8.Hresp), 64'h1);
      chk("n8_oob_cnt", 64'(bus8.err_cnt), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
